// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU control codes, multiply FSM states and default datapath width.
package cpu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_BEQ = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: EX-stage request side and stall/result side of the multiply sequencer.
interface mul_sequencer_if #(parameter int WIDTH = cpu_pkg::WIDTH_DEF);
  logic [3:0] alu_ctrl_i;
  logic ex_valid_i;
  logic flush_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic stall_o;
  logic busy_o;
  logic [WIDTH-1:0] result_o;
  logic result_valid_o;
  modport master (output alu_ctrl_i, ex_valid_i, flush_i, src1_i, src2_i,
                  input stall_o, busy_o, result_o, result_valid_o);
  modport slave (input alu_ctrl_i, ex_valid_i, flush_i, src1_i, src2_i,
                 output stall_o, busy_o, result_o, result_valid_o);
endinterface

// File: rtl/mul_shift_add_step.sv
// mul_shift_add_step: one combinational shift-add iteration of the multiplier.
module mul_shift_add_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] mcand_nx,
  output logic [WIDTH-1:0] mplier_nx
);
  always_comb begin
    acc_nx = mplier[0] ? acc + mcand : acc;
    mcand_nx = mcand << 1;
    mplier_nx = mplier >> 1;
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiply controller for the EX stage.
// Define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_sequencer import cpu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input logic clk_i,
  input logic rst_i,
  mul_sequencer_if.slave bus
);
  mul_state_e state, state_nx, first_st;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, res_q, acc_nx, mcand_nx, mplier_nx;
  logic start, last;
  mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .mcand(mcand), .mplier(mplier),
    .acc_nx(acc_nx), .mcand_nx(mcand_nx), .mplier_nx(mplier_nx)
  );
  assign start = state == IDLE && bus.ex_valid_i && bus.alu_ctrl_i == ALU_MUL && !bus.flush_i;
`ifdef MUL_EARLY_OUT_EN
  assign last = cnt == CNT_W'(WIDTH - 1) || mplier_nx == '0;
  assign first_st = bus.src2_i == '0 ? DONE : BUSY;
`else
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign first_st = BUSY;
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? first_st : IDLE) :
               state == BUSY ? (bus.flush_i ? IDLE : last ? DONE : BUSY) : IDLE;
    // stall must stay low while reset holds even if a MUL is sitting in EX
    bus.stall_o = rst_i && (start || (state == BUSY && !bus.flush_i));
    bus.busy_o = state != IDLE;
    bus.result_valid_o = state == DONE && !bus.flush_i;
    bus.result_o = state == DONE ? acc : res_q;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      res_q <= '0;
    end else begin
      if (start) begin
        acc <= '0;
        mcand <= bus.src1_i;
        mplier <= bus.src2_i;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= acc_nx;
        mcand <= mcand_nx;
        mplier <= mplier_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) res_q <= acc;
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed checks of the multiply sequencer (default or early-out build).
module tb_mul_sequencer;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int stalls, valids, cnt;
  logic [31:0] res;
  mul_sequencer_if #(.WIDTH(32)) bus ();
  mul_sequencer dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int st, output logic [31:0] r, output int v);
    bus.alu_ctrl_i = 4'd3;
    bus.ex_valid_i = 1'b1;
    bus.src1_i = a;
    bus.src2_i = b;
    st = 0;
    v = 0;
    r = 'x;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.stall_o) st++;
      if (bus.result_valid_o) begin
        v++;
        r = bus.result_o;
      end
      @(negedge clk);
      if (v != 0) break;
    end
  endtask
  initial begin
    bus.alu_ctrl_i = 4'd3;
    bus.ex_valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.src1_i = 32'd3;
    bus.src2_i = 32'd5;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.result_valid_o}, 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_mul(32'd3, 32'd5, stalls, res, valids);
    chk("basic_stall", 32'(stalls), EO ? 32'd4 : 32'd33);
    chk("basic_res", res, 32'd15);
    chk("basic_nvalid", 32'(valids), 32'd1);
    bus.ex_valid_i = 1'b0;
    #1;
    chk("basic_no_retrigger", {31'd0, bus.busy_o}, 32'd0);
    chk("basic_hold", bus.result_o, 32'd15);
    @(negedge clk);
    run_mul(32'hFFFF_FFFF, 32'd7, stalls, res, valids);
    chk("neg_stall", 32'(stalls), EO ? 32'd4 : 32'd33);
    chk("neg_res", res, 32'hFFFF_FFF9);
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    run_mul(32'h8000_0000, 32'd2, stalls, res, valids);
    chk("wrap_stall", 32'(stalls), EO ? 32'd3 : 32'd33);
    chk("wrap_res", res, 32'd0);
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    run_mul(32'd1234, 32'd0, stalls, res, valids);
    chk("zero_stall", 32'(stalls), EO ? 32'd1 : 32'd33);
    chk("zero_res", res, 32'd0);
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    bus.alu_ctrl_i = 4'd2;
    bus.ex_valid_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.stall_o || bus.busy_o) cnt++;
      @(negedge clk);
    end
    chk("nonmul_quiet", 32'(cnt), 32'd0);
    bus.alu_ctrl_i = 4'd3;
    bus.ex_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.stall_o || bus.busy_o) cnt++;
      @(negedge clk);
    end
    chk("bubble_quiet", 32'(cnt), 32'd0);
    bus.src1_i = 32'd11;
    bus.src2_i = 32'hFFFF_FFFF;
    bus.ex_valid_i = 1'b1;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall_drop", {31'd0, bus.stall_o}, 32'd0);
    chk("flush_busy_cycle", {31'd0, bus.busy_o}, 32'd1);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    #1;
    chk("flush_idle", {31'd0, bus.busy_o}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.result_valid_o) cnt++;
    end
    chk("flush_no_valid", 32'(cnt), 32'd0);
    @(negedge clk);
    run_mul(32'd6, 32'd7, stalls, res, valids);
    chk("b2b1_stall", 32'(stalls), EO ? 32'd4 : 32'd33);
    chk("b2b1_res", res, 32'd42);
    run_mul(32'd2, 32'd9, stalls, res, valids);
    chk("b2b2_stall", 32'(stalls), EO ? 32'd5 : 32'd33);
    chk("b2b2_res", res, 32'd18);
    chk("b2b2_nvalid", 32'(valids), 32'd1);
    bus.ex_valid_i = 1'b0;
    @(negedge clk);
    bus.src1_i = 32'd3;
    bus.src2_i = 32'h8000_0001;
    bus.ex_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    bus.ex_valid_i = 1'b0;
    #1;
    chk("mid_busy_pre", {31'd0, bus.busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.result_valid_o}, 32'd0);
    chk("mid_rst_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
